axi4_lite_master: RTL and testbench

- AXI4-Lite initiator; the counterpart of the bridge's AXI4-Lite slave port.
- Accepts single read/write commands on a simple valid/ready command port and drives one AXI4-Lite transaction at a time.
- Returns the read data and the response code on a valid/ready response port.
- Used as the bus driver in the bridge test environment and by on-chip control logic that needs to reach AXI4-Lite register spaces.

---
 rtl/axi4_lite_master.sv | 215 +++++++++++++++++++++
 tb/tb_axi4_lite_master.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_master.sv
// AXI4-Lite initiator: takes one read/write command at a time on a valid/ready
// command port, runs the matching AXI4-Lite transaction and returns the result
// on a valid/ready response port. All AXI and response outputs are registered.
module axi4_lite_master #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDRESS    = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  // Command port
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDRESS-1:0]        cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  // Response port
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_write,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  // AXI4-Lite write address / data / response
  output logic [ADDRESS-1:0]        M_AWADDR,
  output logic                      M_AWVALID,
  input  logic                      M_AWREADY,
  output logic [DATA_WIDTH-1:0]     M_WDATA,
  output logic [DATA_WIDTH/8-1:0]   M_WSTRB,
  output logic                      M_WVALID,
  input  logic                      M_WREADY,
  input  logic [1:0]                M_BRESP,
  input  logic                      M_BVALID,
  output logic                      M_BREADY,
  // AXI4-Lite read address / data
  output logic [ADDRESS-1:0]        M_ARADDR,
  output logic                      M_ARVALID,
  input  logic                      M_ARREADY,
  input  logic [DATA_WIDTH-1:0]     M_RDATA,
  input  logic [1:0]                M_RRESP,
  input  logic                      M_RVALID,
  output logic                      M_RREADY
);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StWresp,
    StRaddr,
    StRdata,
    StRsp
  } state_e;

  state_e                    state_q, state_d;
  logic                      cmd_ready_q, cmd_ready_d;
  logic [ADDRESS-1:0]        addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic                      bready_q, bready_d;
  logic                      arvalid_q, arvalid_d;
  logic                      rready_q, rready_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                rsp_resp_q, rsp_resp_d;

  // Next-state logic: every register holds unless the current state moves it.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          if (cmd_write) begin
            state_d   = StWrite;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = StRaddr;
            arvalid_d = 1'b1;
          end
        end
      end
      StWrite: begin
        // AW and W complete independently, in any order.
        if (awvalid_q && M_AWREADY) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && M_WREADY) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          state_d  = StWresp;
          bready_d = 1'b1;
        end
      end
      StWresp: begin
        if (M_BVALID) begin
          rsp_resp_d  = M_BRESP;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_valid_d = 1'b1;
          bready_d    = 1'b0;
          state_d     = StRsp;
        end
      end
      StRaddr: begin
        if (M_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StRdata;
        end
      end
      StRdata: begin
        if (M_RVALID) begin
          rsp_rdata_d = M_RDATA;
          rsp_resp_d  = M_RRESP;
          rsp_write_d = 1'b0;
          rsp_valid_d = 1'b1;
          rready_d    = 1'b0;
          state_d     = StRsp;
        end
      end
      StRsp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Registered so cmd_ready is high exactly while the state register holds IDLE.
    cmd_ready_d = (state_d == StIdle);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign M_AWADDR  = addr_q;
  assign M_AWVALID = awvalid_q;
  assign M_WDATA   = wdata_q;
  assign M_WSTRB   = wstrb_q;
  assign M_WVALID  = wvalid_q;
  assign M_BREADY  = bready_q;
  assign M_ARADDR  = addr_q;
  assign M_ARVALID = arvalid_q;
  assign M_RREADY  = rready_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master: table of directed transactions against a small
// register-file slave with per-channel delays, plus reset, response-stall and
// random alternating write/read sequences.
module tb_axi4_lite_master;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] M_AWADDR, M_WDATA, M_ARADDR, M_RDATA = '0;
  logic [3:0]  M_WSTRB;
  logic        M_AWVALID, M_AWREADY = 1'b0, M_WVALID, M_WREADY = 1'b0;
  logic [1:0]  M_BRESP = '0, M_RRESP = '0;
  logic        M_BVALID = 1'b0, M_BREADY, M_ARVALID, M_ARREADY = 1'b0;
  logic        M_RVALID = 1'b0, M_RREADY;

  axi4_lite_master #(.DATA_WIDTH(32), .ADDRESS(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
  );

  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Protocol monitor: counts handshakes, captures their payload and flags any
  // VALID retracted (or payload changed) before its READY.
  int cyc = 0;
  int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, rsp_cnt = 0;
  int aw_hs_cyc = 0, w_hs_cyc = 0;
  logic [31:0] aw_hs_addr, w_hs_data, ar_hs_addr;
  logic [3:0]  w_hs_strb;
  bit aw_pend = 0, w_pend = 0, ar_pend = 0;
  logic [31:0] aw_pend_addr, w_pend_data, ar_pend_addr;
  logic [3:0]  w_pend_strb;

  always @(posedge ACLK) begin
    cyc++;
    if (ARESET) begin
      aw_pend = 0; w_pend = 0; ar_pend = 0;
    end else begin
      if (aw_pend) check("aw_hold", {M_AWVALID, M_AWADDR[30:0]}, {1'b1, aw_pend_addr[30:0]});
      if (w_pend) check("w_hold", {M_WVALID, M_WSTRB, M_WDATA[26:0]},
                        {1'b1, w_pend_strb, w_pend_data[26:0]});
      if (ar_pend) check("ar_hold", {M_ARVALID, M_ARADDR[30:0]}, {1'b1, ar_pend_addr[30:0]});
      aw_pend = M_AWVALID && !M_AWREADY; aw_pend_addr = M_AWADDR;
      w_pend  = M_WVALID && !M_WREADY;   w_pend_data = M_WDATA; w_pend_strb = M_WSTRB;
      ar_pend = M_ARVALID && !M_ARREADY; ar_pend_addr = M_ARADDR;
      if (M_AWVALID && M_AWREADY) begin aw_hs++; aw_hs_addr = M_AWADDR; aw_hs_cyc = cyc; end
      if (M_WVALID && M_WREADY) begin
        w_hs++; w_hs_data = M_WDATA; w_hs_strb = M_WSTRB; w_hs_cyc = cyc;
      end
      if (M_BVALID && M_BREADY) b_hs++;
      if (M_ARVALID && M_ARREADY) begin ar_hs++; ar_hs_addr = M_ARADDR; end
      if (M_RVALID && M_RREADY) r_hs++;
      if (rsp_valid) rsp_cnt++;
    end
  end

  logic [31:0] mem [16];

  // One command end to end. Writes: d0/d1 = AW/W ready waits, d2 = B delay.
  // Reads: d0 = AR ready wait, d2 = R delay. hold = cycles rsp_ready is held low,
  // during which a stray write command is presented and must be ignored.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int d0, input int d1, input int d2,
                         input logic [1:0] resp, input int hold,
                         output logic [31:0] o_rdata, output logic [1:0] o_resp,
                         output logic o_write);
    int aw0, w0, b0, ar0, r0, awc, wc, bc, arc, rc, hc, n;
    bit got, wrote;
    logic [31:0] s_rdata;
    logic [1:0]  s_resp;
    logic        s_write;
    @(negedge ACLK);
    check("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs; ar0 = ar_hs; r0 = r_hs;
    awc = 0; wc = 0; bc = 0; arc = 0; rc = 0; hc = 0; n = 0;
    got = 0; wrote = 0;
    o_rdata = '0; o_resp = '0; o_write = 1'b0;
    s_rdata = '0; s_resp = '0; s_write = 1'b0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
    while (!got && n < 300) begin
      @(negedge ACLK);
      n++;
      cmd_valid = 1'b0;
      M_AWREADY = 1'b0;
      if (M_AWVALID && aw_hs == aw0) begin
        if (awc >= d0) M_AWREADY = 1'b1; else awc++;
      end
      M_WREADY = 1'b0;
      if (M_WVALID && w_hs == w0) begin
        if (wc >= d1) M_WREADY = 1'b1; else wc++;
      end
      if (aw_hs > aw0 && w_hs > w0 && !wrote) begin
        for (int b = 0; b < 4; b++)
          if (w_hs_strb[b]) mem[aw_hs_addr[5:2]][8*b +: 8] = w_hs_data[8*b +: 8];
        wrote = 1;
      end
      M_BVALID = 1'b0;
      if (wrote && b_hs == b0) begin
        if (bc >= d2) begin M_BVALID = 1'b1; M_BRESP = resp; end else bc++;
      end
      M_ARREADY = 1'b0;
      if (M_ARVALID && ar_hs == ar0) begin
        if (arc >= d0) M_ARREADY = 1'b1; else arc++;
      end
      M_RVALID = 1'b0;
      if (ar_hs > ar0 && r_hs == r0) begin
        if (rc >= d2) begin
          M_RVALID = 1'b1; M_RDATA = mem[ar_hs_addr[5:2]]; M_RRESP = resp;
        end else rc++;
      end
      rsp_ready = 1'b0;
      if (rsp_valid) begin
        if (hc == 0) begin
          s_rdata = rsp_rdata; s_resp = rsp_resp; s_write = rsp_write;
        end else begin
          check("rsp_stable", {rsp_valid, s_write, s_resp, rsp_rdata[27:0]},
                {1'b1, rsp_write, rsp_resp, s_rdata[27:0]});
          check("cmd_ready_busy", {31'b0, cmd_ready}, 32'd0);
        end
        if (hc >= hold) begin
          rsp_ready = 1'b1;
          o_rdata = rsp_rdata; o_resp = rsp_resp; o_write = rsp_write;
          got = 1;
        end else begin
          cmd_valid = 1'b1; cmd_write = 1'b1;
        end
        hc++;
      end
    end
    check("txn_timeout", {31'b0, got}, 32'd1);
    @(negedge ACLK);
    rsp_ready = 1'b0; cmd_valid = 1'b0;
    M_AWREADY = 1'b0; M_WREADY = 1'b0; M_ARREADY = 1'b0; M_BVALID = 1'b0; M_RVALID = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          d0;
    int          d1;
    int          d2;
    logic [1:0]  resp;
    logic [31:0] exp_rdata;
    int          skew;  // expected AW handshake cycle minus W handshake cycle
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] g_rdata;
  logic [1:0]  g_resp;
  logic        g_write;
  logic [31:0] exp_mem [4];
  int          aw0, w0, b0, ar0, r0, rsp0;

  initial begin
    vecs[0] = '{1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 32'h0, 0};
    vecs[1] = '{1'b1, 32'h08, 32'h12345678, 4'hF, 3, 0, 1, 2'b00, 32'h0, 3};
    vecs[2] = '{1'b0, 32'h08, 32'h0,        4'h0, 2, 0, 0, 2'b10, 32'h12345678, 0};
    vecs[3] = '{1'b1, 32'h0C, 32'hAABBCCDD, 4'h5, 0, 2, 0, 2'b01, 32'h0, -2};
    vecs[4] = '{1'b0, 32'h0C, 32'h0,        4'h0, 1, 0, 3, 2'b00, 32'h00BB00DD, 0};
    vecs[5] = '{1'b1, 32'h04, 32'h11223344, 4'hC, 1, 1, 2, 2'b11, 32'h0, 0};
    vecs[6] = '{1'b0, 32'h04, 32'h0,        4'h0, 0, 0, 0, 2'b11, 32'h1122BEEF, 0};
    vecs[7] = '{1'b0, 32'h00, 32'h0,        4'h0, 0, 0, 1, 2'b00, 32'h0, 0};
    for (int i = 0; i < 16; i++) mem[i] = '0;
    for (int i = 0; i < 4; i++) exp_mem[i] = '0;

    repeat (3) @(negedge ACLK);
    ARESET = 1'b0;
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("rst_valids", {26'b0, M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, rsp_valid},
          32'd0);
    check("rst_rsp", {rsp_write, rsp_resp, rsp_rdata[28:0]}, 32'd0);
    check("rst_addr", M_AWADDR | M_ARADDR, 32'd0);
    check("rst_wdata", M_WDATA | {28'b0, M_WSTRB}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      aw0 = aw_hs; w0 = w_hs; b0 = b_hs; ar0 = ar_hs; r0 = r_hs;
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].d0, vecs[i].d1,
              vecs[i].d2, vecs[i].resp, 0, g_rdata, g_resp, g_write);
      check($sformatf("v%0d_write", i), {31'b0, g_write}, {31'b0, vecs[i].wr});
      check($sformatf("v%0d_rdata", i), g_rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_resp", i), {30'b0, g_resp}, {30'b0, vecs[i].resp});
      if (vecs[i].wr) begin
        check($sformatf("v%0d_hs_count", i), (aw_hs - aw0) * 100 + (w_hs - w0) * 10 + (b_hs - b0),
              32'd111);
        check($sformatf("v%0d_awaddr", i), aw_hs_addr, vecs[i].addr);
        check($sformatf("v%0d_wdata", i), w_hs_data, vecs[i].wdata);
        check($sformatf("v%0d_wstrb", i), {28'b0, w_hs_strb}, {28'b0, vecs[i].strb});
        check($sformatf("v%0d_skew", i), aw_hs_cyc - w_hs_cyc, vecs[i].skew);
      end else begin
        check($sformatf("v%0d_hs_count", i), (ar_hs - ar0) * 10 + (r_hs - r0) + (aw_hs - aw0),
              32'd11);
        check($sformatf("v%0d_araddr", i), ar_hs_addr, vecs[i].addr);
      end
    end

    // Response stalled 4 cycles; a write command presented meanwhile is ignored.
    aw0 = aw_hs;
    run_txn(1'b0, 32'h08, 32'h0, 4'h0, 0, 0, 2, 2'b00, 4, g_rdata, g_resp, g_write);
    check("hold_rdata", g_rdata, 32'h12345678);
    check("hold_write", {31'b0, g_write}, 32'd0);
    repeat (3) @(negedge ACLK);
    check("hold_no_stray_cmd", aw_hs - aw0, 32'd0);
    check("hold_back_idle", {31'b0, cmd_ready}, 32'd1);

    // Reset while AW/W are pending: transaction abandoned, no response.
    @(negedge ACLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h30; cmd_wdata = 32'hCAFEF00D;
    cmd_wstrb = 4'hF;
    @(negedge ACLK);
    cmd_valid = 1'b0;
    check("mid_awvalid", {30'b0, M_AWVALID, cmd_ready}, 32'd2);
    rsp0 = rsp_cnt; aw0 = aw_hs;
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    check("mid_rst_valids",
          {26'b0, M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, rsp_valid}, 32'd0);
    check("mid_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    repeat (5) @(negedge ACLK);
    check("mid_rst_no_rsp", rsp_cnt - rsp0, 32'd0);
    check("mid_rst_no_aw", {aw_hs - aw0} | {31'b0, M_AWVALID}, 32'd0);

    // Alternating random writes/reads over four words in a fresh region.
    for (int i = 0; i < 16; i++) begin
      logic [1:0]  idx;
      logic [31:0] d;
      logic [3:0]  s;
      logic [1:0]  r;
      idx = 2'($urandom_range(0, 3));
      d = $urandom;
      s = 4'($urandom_range(1, 15));
      r = 2'($urandom_range(0, 3));
      if (i % 2 == 0) begin
        run_txn(1'b1, 32'h20 + {28'b0, idx, 2'b00}, d, s, $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3), r, $urandom_range(0, 2),
                g_rdata, g_resp, g_write);
        for (int b = 0; b < 4; b++) if (s[b]) exp_mem[idx][8*b +: 8] = d[8*b +: 8];
        check($sformatf("rnd%0d_wresp", i), {29'b0, g_write, g_resp}, {29'b0, 1'b1, r});
      end else begin
        run_txn(1'b0, 32'h20 + {28'b0, idx, 2'b00}, 32'h0, 4'h0, $urandom_range(0, 3), 0,
                $urandom_range(0, 3), r, $urandom_range(0, 2), g_rdata, g_resp, g_write);
        check($sformatf("rnd%0d_rdata", i), g_rdata, exp_mem[idx]);
        check($sformatf("rnd%0d_rresp", i), {29'b0, g_write, g_resp}, {29'b0, 1'b0, r});
      end
    end

    repeat (2) @(negedge ACLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
